reset_sequencer: RTL and testbench

//   Parametrised reset generator for the Ethernet datapath. It holds NUM_CH downstream reset

---
 rtl/reset_sequencer.sv | 155 +++++++++++++++
 tb/tb_reset_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer for the Ethernet datapath: waits for a filtered PLL lock, holds all
// downstream domains in reset, then releases them one by one with a fixed gap.
module reset_sequencer #(
    parameter int                   NUM_CH          = 4,
    parameter logic [NUM_CH-1:0]    ACTIVE_LOW_MASK = NUM_CH'(1'b1),
    parameter int                   LOCK_FILTER     = 4,
    parameter int                   HOLD_CYCLES     = 16,
    parameter int                   STAGE_GAP       = 8,
    parameter int                   CNT_W           = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_lock,
    input  logic                sw_rst,
    output logic [NUM_CH-1:0]   ch_rst,
    output logic                done,
    output logic [7:0]          lock_loss_cnt
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LOCK_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_CH - 1);
    // Output pattern with every channel held in reset, honouring each channel's polarity.
    localparam logic [NUM_CH-1:0] ASSERT_ALL = ~ACTIVE_LOW_MASK;

    typedef enum logic [1:0] {
        LOCK_WAIT = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             state_r;
    logic               sync_meta_r;
    logic               lock_s;
    logic [CNT_W-1:0]   lock_cnt_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic               abort_s;

    // Two-flop synchroniser for the asynchronous PLL lock indicator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b0;
            lock_s      <= 1'b0;
        end else begin
            sync_meta_r <= pll_lock;
            lock_s      <= sync_meta_r;
        end
    end

    // Abort request: only meaningful once lock has been accepted.
    always_comb begin
        if (state_r == LOCK_WAIT) begin
            abort_s = 1'b0;
        end else begin
            abort_s = !lock_s || sw_rst;
        end
    end

    // Sequencing FSM with registered channel resets, done flag and lock-loss counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= LOCK_WAIT;
            lock_cnt_r    <= CNT_ZERO;
            cnt_r         <= CNT_ZERO;
            idx_r         <= IDX_ZERO;
            ch_rst        <= ASSERT_ALL;
            done          <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else if (abort_s) begin
            state_r    <= LOCK_WAIT;
            lock_cnt_r <= CNT_ZERO;
            cnt_r      <= CNT_ZERO;
            idx_r      <= IDX_ZERO;
            ch_rst     <= ASSERT_ALL;
            done       <= 1'b0;
            // A simultaneous sw_rst and lock loss still counts as one lock loss.
            if (!lock_s && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end else begin
                lock_loss_cnt <= lock_loss_cnt;
            end
        end else begin
            case (state_r)
                LOCK_WAIT: begin
                    ch_rst <= ASSERT_ALL;
                    done   <= 1'b0;
                    cnt_r  <= CNT_ZERO;
                    idx_r  <= IDX_ZERO;
                    if (!lock_s || sw_rst) begin
                        lock_cnt_r <= CNT_ZERO;
                    end else if (lock_cnt_r == LOCK_LAST) begin
                        lock_cnt_r <= CNT_ZERO;
                        state_r    <= HOLD;
                    end else begin
                        lock_cnt_r <= lock_cnt_r + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        ch_rst[0] <= ACTIVE_LOW_MASK[0];
                        if (NUM_CH == 1) begin
                            state_r <= RUN;
                            done    <= 1'b1;
                        end else begin
                            state_r <= RELEASE;
                            idx_r   <= IDX_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r <= CNT_ZERO;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (IDX_W'(i) == idx_r) begin
                                ch_rst[i] <= ACTIVE_LOW_MASK[i];
                            end
                        end
                        if (idx_r == LAST_IDX) begin
                            state_r <= RUN;
                            done    <= 1'b1;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RUN: begin
                    done <= 1'b1;
                end
                default: begin
                    state_r    <= LOCK_WAIT;
                    lock_cnt_r <= CNT_ZERO;
                    cnt_r      <= CNT_ZERO;
                    idx_r      <= IDX_ZERO;
                    ch_rst     <= ASSERT_ALL;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: fixed timing table, hand-written corner
// sequences and randomised lock/sw_rst traffic against a time-based reference model.
module tb_reset_sequencer;

    localparam int LF   = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       sw_rst;
    logic [3:0] ch_rst;
    logic       done;
    logic [7:0] lock_loss_cnt;
    logic [0:0] ch_rst1;
    logic       done1;
    logic [7:0] lock_loss_cnt1;

    int n_vec = 0;
    int n_err = 0;

    reset_sequencer dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .sw_rst(sw_rst),
        .ch_rst(ch_rst), .done(done), .lock_loss_cnt(lock_loss_cnt)
    );

    reset_sequencer #(.NUM_CH(1), .ACTIVE_LOW_MASK(1'b0)) dut1 (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .sw_rst(sw_rst),
        .ch_rst(ch_rst1), .done(done1), .lock_loss_cnt(lock_loss_cnt1)
    );

    always #5 clk = ~clk;

    // Reference model: lock acceptance time plus elapsed edges decide how many channels are free.
    int m_s1, m_s2, m_streak, m_elapsed, m_llc;
    bit m_locked;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_streak = 0; m_elapsed = 0; m_llc = 0; m_locked = 0;
    endtask

    task automatic model_edge();
        int ls;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = int'(pll_lock);
        if (!m_locked) begin
            if (ls == 0 || sw_rst) m_streak = 0;
            else if (m_streak + 1 >= LF) begin
                m_locked = 1; m_elapsed = 0; m_streak = 0;
            end else m_streak++;
        end else if (ls == 0 || sw_rst) begin
            m_locked = 0; m_streak = 0;
            if (ls == 0 && m_llc < 255) m_llc++;
        end else m_elapsed++;
    endtask

    function automatic int m_released(input int n);
        int r;
        if (!m_locked || m_elapsed < HOLD) return 0;
        r = 1 + (m_elapsed - HOLD) / GAP;
        return (r > n) ? n : r;
    endfunction

    function automatic logic [3:0] m_ch4();
        logic [3:0] a;
        for (int k = 0; k < 4; k++) a[k] = (k >= m_released(4));
        return a ^ 4'b0001;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        @(negedge clk);
    endtask

    task automatic chk_model();
        chk("ch_rst", 32'(ch_rst), 32'(m_ch4()));
        chk("done", 32'(done), 32'(m_released(4) == 4));
        chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_llc));
        chk("ch_rst1", 32'(ch_rst1), 32'(m_released(1) == 0));
        chk("done1", 32'(done1), 32'(m_released(1) == 1));
        chk("lock_loss_cnt1", 32'(lock_loss_cnt1), 32'(m_llc));
    endtask

    task automatic tick_chk();
        tick();
        chk_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int         adv;
        logic       lock;
        logic       sw;
        logic [3:0] ch;
        logic       dn;
        logic [7:0] llc;
        logic       ch1;
        logic       dn1;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Edge numbers below count from the first rising edge with rst low.
        tbl[0]  = '{21, 1'b1, 1'b0, 4'b1110, 1'b0, 8'd0, 1'b1, 1'b0};
        tbl[1]  = '{1,  1'b1, 1'b0, 4'b1111, 1'b0, 8'd0, 1'b0, 1'b1};
        tbl[2]  = '{7,  1'b1, 1'b0, 4'b1111, 1'b0, 8'd0, 1'b0, 1'b1};
        tbl[3]  = '{1,  1'b1, 1'b0, 4'b1101, 1'b0, 8'd0, 1'b0, 1'b1};
        tbl[4]  = '{8,  1'b1, 1'b0, 4'b1001, 1'b0, 8'd0, 1'b0, 1'b1};
        tbl[5]  = '{7,  1'b1, 1'b0, 4'b1001, 1'b0, 8'd0, 1'b0, 1'b1};
        tbl[6]  = '{1,  1'b1, 1'b0, 4'b0001, 1'b1, 8'd0, 1'b0, 1'b1};
        tbl[7]  = '{1,  1'b0, 1'b0, 4'b0001, 1'b1, 8'd0, 1'b0, 1'b1};
        tbl[8]  = '{1,  1'b1, 1'b0, 4'b0001, 1'b1, 8'd0, 1'b0, 1'b1};
        tbl[9]  = '{1,  1'b1, 1'b0, 4'b1110, 1'b0, 8'd1, 1'b1, 1'b0};
        tbl[10] = '{19, 1'b1, 1'b0, 4'b1110, 1'b0, 8'd1, 1'b1, 1'b0};
        tbl[11] = '{1,  1'b1, 1'b0, 4'b1111, 1'b0, 8'd1, 1'b0, 1'b1};

        rst = 1'b1; pll_lock = 1'b1; sw_rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset ch_rst", 32'(ch_rst), 32'h0000000E);
        chk("reset done", 32'(done), 32'd0);
        chk("reset lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        chk("reset ch_rst1", 32'(ch_rst1), 32'd1);
        do_reset();

        // Nominal release timing, lock loss in RUN and the single-channel variant.
        for (int i = 0; i < 12; i++) begin
            pll_lock = tbl[i].lock;
            sw_rst   = tbl[i].sw;
            repeat (tbl[i].adv) tick();
            chk($sformatf("tbl%0d ch_rst", i), 32'(ch_rst), 32'(tbl[i].ch));
            chk($sformatf("tbl%0d done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("tbl%0d lock_loss_cnt", i), 32'(lock_loss_cnt), 32'(tbl[i].llc));
            chk($sformatf("tbl%0d ch_rst1", i), 32'(ch_rst1), 32'(tbl[i].ch1));
            chk($sformatf("tbl%0d done1", i), 32'(done1), 32'(tbl[i].dn1));
        end

        // Lock toggling 1,1,1,0 never satisfies the filter.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            pll_lock = (i % 4 != 3);
            tick_chk();
        end
        chk("glitch ch_rst", 32'(ch_rst), 32'h0000000E);
        chk("glitch lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);

        // sw_rst in RELEASE with ch0 and ch1 already released.
        pll_lock = 1'b1;
        do_reset();
        repeat (32) tick_chk();
        chk("pre sw_rst ch_rst", 32'(ch_rst), 32'h0000000D);
        sw_rst = 1'b1;
        tick_chk();
        sw_rst = 1'b0;
        chk("sw_rst ch_rst", 32'(ch_rst), 32'h0000000E);
        chk("sw_rst lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        repeat (19) tick_chk();
        chk("sw_rst rerelease-1", 32'(ch_rst), 32'h0000000E);
        tick_chk();
        chk("sw_rst rerelease", 32'(ch_rst), 32'h0000000F);

        // 300 lock-loss events saturate the counter.
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b1;
            repeat (8) tick_chk();
            pll_lock = 1'b0;
            repeat (2) tick_chk();
        end
        chk("saturated lock_loss_cnt", 32'(lock_loss_cnt), 32'd255);

        // Asynchronous rst in the middle of RELEASE.
        pll_lock = 1'b1;
        repeat (32) tick_chk();
        chk("mid release ch_rst", 32'(ch_rst), 32'h0000000D);
        #2 rst = 1'b1;
        #1;
        chk("async rst ch_rst", 32'(ch_rst), 32'h0000000E);
        chk("async rst done1", 32'(done1), 32'd0);
        chk("async rst ch_rst1", 32'(ch_rst1), 32'd1);
        chk("async rst lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomised lock drops and software resets.
        for (int i = 0; i < 5000; i++) begin
            pll_lock = ($urandom_range(0, 99) >= 2);
            sw_rst   = ($urandom_range(0, 149) == 0);
            tick_chk();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
